tff_bank_ctrl: RTL and testbench
================================

# tff_bank_ctrl

Sequencing controller for a bank of WIDTH external T flip-flops that hold a count value. It accepts load, count-up, count-down and stop commands over a valid/ready handshake. Each cycle it drives the bank's per-bit toggle inputs from the bank's current outputs. Because the T flip-flops have no reset of their own, the controller also clears the bank after every reset.

## Interface
- WIDTH, 4, number of T flip-flops in the controlled bank (≥2)
- clk  in  1  rising-edge clock shared with the T flip-flop bank
- rst  in  1  synchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  controller can accept a command this cycle
- cmd_op  in  2  00 LOAD, 01 COUNT_UP, 10 COUNT_DOWN, 11 STOP
- cmd_data  in  WIDTH  load value (LOAD) or terminal value (COUNT_UP/COUNT_DOWN)
- q  in  WIDTH  current outputs of the T flip-flop bank
- t  out  WIDTH  toggle inputs to the bank; bit i drives flip-flop i
- busy  out  1  state ≠ IDLE
- done  out  1  one-cycle pulse on completion of LOAD or COUNT
- err  out  1  one-cycle pulse when a command is dropped

## Operation
- Handshake: a command is accepted on a rising edge with cmd_valid && cmd_ready. cmd_op and cmd_data are sampled only at that edge.
- States: CLEAR, IDLE, LOAD, RUN_UP, RUN_DOWN, DONE. Registered state, terminal value `tgt`, load value `ld`, done and err.
- t is combinational from state, q and registers. q comes from registers, so there is no combinational loop.
- rst=1: t=0 forced combinationally. At the edge: state←CLEAR, tgt←0, ld←0, done←0, err←0.
- CLEAR: t=q, which zeroes the bank at the next edge. cmd_ready=0. Next state is IDLE.
- IDLE: t=0, cmd_ready=1.
  - LOAD → LOAD state, ld←cmd_data.
  - COUNT_UP → RUN_UP, tgt←cmd_data.
  - COUNT_DOWN → RUN_DOWN, tgt←cmd_data.
  - STOP → accepted, no effect, no err.
- LOAD: t=q^ld, so q=ld after the edge. cmd_ready=0. Next state is DONE.
- RUN_UP, q≠tgt: t[0]=1 and t[i]=&q[i-1:0], which increments mod 2^WIDTH (wrap 2^WIDTH−1→0).
- RUN_DOWN, q≠tgt: t[0]=1 and t[i]=&~q[i-1:0], which decrements mod 2^WIDTH (wrap 0→2^WIDTH−1).
- RUN_*, q==tgt: t=0. Next state is DONE.
- RUN_*: cmd_ready=1.
  - Accepted STOP: t=0 in that cycle, next state IDLE, no done.
  - Accepted LOAD/COUNT_*: dropped. err pulses, counting continues unchanged.
- Simultaneous STOP accepted and q==tgt in RUN_*: STOP wins. Next state IDLE, done stays 0.
- Terminal value equal to q at entry: zero steps, and DONE follows immediately.
- DONE: t=0, cmd_ready=0, done=1. Next state is IDLE.
- busy=1 in every state except IDLE. err is a registered pulse set on the edge of a dropped accept.

## Timing
- Reset values: state CLEAR, t=0 (while rst=1), cmd_ready=0, busy=1, done=0, err=0.
- After the reset release edge:
  - First cycle: state=CLEAR.
  - Second cycle: bank=0, state IDLE, cmd_ready=1.
- LOAD accepted at edge E0: state LOAD in cycle E0–E1; q=ld from E1; done=1 in cycle E1–E2; IDLE from E2.
- COUNT with k=(tgt−q0) mod 2^WIDTH (up) or (q0−tgt) mod 2^WIDTH (down), accepted at E0:
  - q steps once per edge at E1…Ek.
  - done=1 in cycle Ek+1–Ek+2.
  - IDLE from Ek+2.
  - Total: k+2 edges from acceptance to IDLE.
- STOP accepted at edge Es during RUN: q frozen at its value after Es; IDLE from Es.
- Reset mid-operation: t=0 immediately (combinational), so q holds its value. The bank is then cleared by CLEAR, with no done or err.
- No command is lost or duplicated. Back-to-back commands give at most one accept per cycle; none is accepted in CLEAR, LOAD or DONE.

## Test plan
- Reset clear: bank preset to 4'b1011, rst high for 3 cycles, then low → t=4'b1011 in the CLEAR cycle, q=0 on the next cycle, cmd_ready=1.
- Load: LOAD 4'hA from q=0 → t=4'hA for one cycle, q=4'hA, done pulses exactly once, IDLE 2 edges after accept.
- Count up with wrap: q=4'hE, COUNT_UP tgt=4'h2 → q sequence F,0,1,2, done high 5 edges after accept, t=0 while done.
- Count down with wrap and zero-step: q=4'h1, COUNT_DOWN tgt=4'hE → q sequence 0,F,E, done pulses. Then COUNT_UP tgt=4'hE at q=4'hE → no toggle, done 1 edge after accept.
- Stop and drop: COUNT_UP 0→4'h9.
  - At q=3, issue LOAD → err pulse, count continues.
  - At q=5, issue STOP → q stays 5, IDLE, done never asserted.
  - STOP coinciding with q==tgt → IDLE with no done.
- Reset mid-count: rst asserted at q=6 during RUN_UP → t=0 immediately, q holds 6, CLEAR after release zeroes q, no done or err.

Source files
------------

// File: rtl/tff_bank_ctrl_if.sv
// ----------------------------------------------------------------------------
// tff_bank_ctrl_if
//   Command channel of the T flip-flop bank controller.
//   cmd_valid  command present (master -> slave)
//   cmd_ready  slave can accept a command this cycle (slave -> master)
//   cmd_op     00 LOAD, 01 COUNT_UP, 10 COUNT_DOWN, 11 STOP
//   cmd_data   load value or terminal count value
// ----------------------------------------------------------------------------
interface tff_bank_ctrl_if #(
    parameter int WIDTH = 4
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [WIDTH-1:0] cmd_data;

    modport master (output cmd_valid, output cmd_op, output cmd_data, input cmd_ready);
    modport slave  (input cmd_valid, input cmd_op, input cmd_data, output cmd_ready);
endinterface

// File: rtl/tff_bank_ctrl.sv
// ----------------------------------------------------------------------------
// tff_bank_ctrl
//   Sequencing controller for a bank of WIDTH external T flip-flops holding a
//   count value. Executes LOAD / COUNT_UP / COUNT_DOWN / STOP commands by
//   driving the per-bit toggle inputs from the bank's current outputs, and
//   clears the bank after every reset because the flops have no reset.
//
//   clk   rising-edge clock shared with the bank
//   rst   synchronous active-high reset
//   cmd   command channel (slave side of tff_bank_ctrl_if)
//   q     current bank outputs
//   t     toggle inputs to the bank, bit i drives flip-flop i
//   busy  controller not idle
//   done  one-cycle pulse when LOAD or COUNT completes
//   err   one-cycle pulse when a command arriving mid-count is dropped
// ----------------------------------------------------------------------------
module tff_bank_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    tff_bank_ctrl_if.slave   cmd,
    input  logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] t,
    output logic             busy,
    output logic             done,
    output logic             err
);

    typedef enum logic [2:0] {
        S_CLEAR, S_IDLE, S_LOAD, S_RUN_UP, S_RUN_DOWN, S_DONE
    } state_t;

    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_UP   = 2'b01;
    localparam logic [1:0] OP_DOWN = 2'b10;
    localparam logic [1:0] OP_STOP = 2'b11;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] tgt, ld;
    logic [WIDTH-1:0] t_up, t_down;
    logic             in_run, ready, accept, stop_req, drop_req;

    // Toggle patterns for a binary increment / decrement of q: bit i flips
    // when every lower bit is 1 (up) or 0 (down).
    assign t_up[0]   = 1'b1;
    assign t_down[0] = 1'b1;
    for (genvar i = 1; i < WIDTH; i++) begin : g_step
        assign t_up[i]   = &q[i-1:0];
        assign t_down[i] = ~|q[i-1:0];
    end

    assign in_run        = (state == S_RUN_UP) || (state == S_RUN_DOWN);
    assign ready         = !rst && ((state == S_IDLE) || in_run);
    assign cmd.cmd_ready = ready;
    assign accept        = cmd.cmd_valid && ready;
    assign stop_req      = accept && (cmd.cmd_op == OP_STOP);
    assign drop_req      = accept && in_run && (cmd.cmd_op != OP_STOP);
    assign busy          = (state != S_IDLE);

    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_nxt = state;
        t         = '0;
        unique case (state)
            S_CLEAR: begin
                t         = q;
                state_nxt = S_IDLE;
            end
            S_IDLE: begin
                if (accept) begin
                    unique case (cmd.cmd_op)
                        OP_LOAD: state_nxt = S_LOAD;
                        OP_UP:   state_nxt = S_RUN_UP;
                        OP_DOWN: state_nxt = S_RUN_DOWN;
                        OP_STOP: state_nxt = S_IDLE;
                    endcase
                end
            end
            S_LOAD: begin
                t         = q ^ ld;
                state_nxt = S_DONE;
            end
            S_RUN_UP, S_RUN_DOWN: begin
                // A STOP in the same cycle as reaching the target wins.
                if (stop_req) begin
                    state_nxt = S_IDLE;
                end else if (q == tgt) begin
                    state_nxt = S_DONE;
                end else begin
                    t = (state == S_RUN_UP) ? t_up : t_down;
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_CLEAR;
        endcase
        // NOTE: reset must freeze the bank immediately, not one edge later,
        // so the toggles are gated combinationally rather than through state.
        if (rst) begin
            t = '0;
        end
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the values from before the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_CLEAR;
            tgt   <= '0;
            ld    <= '0;
            done  <= 1'b0;
            err   <= 1'b0;
        end else begin
            state <= state_nxt;
            done  <= (state_nxt == S_DONE);
            err   <= drop_req;
            if ((state == S_IDLE) && accept) begin
                if (cmd.cmd_op == OP_LOAD) begin
                    ld <= cmd.cmd_data;
                end else if (cmd.cmd_op != OP_STOP) begin
                    tgt <= cmd.cmd_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_tff_bank_ctrl.sv
// ----------------------------------------------------------------------------
// tb_tff_bank_ctrl
//   Bench for tff_bank_ctrl with a behavioural T flip-flop bank. Inputs are
//   driven 1 time unit after the rising edge and outputs sampled on the
//   falling edge. A reference model tracks the bank value arithmetically and
//   counts remaining steps instead of comparing against the target.
// ----------------------------------------------------------------------------
module tb_tff_bank_ctrl;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] q, t;
    logic         busy, done, err;
    logic         preset_en;
    logic [W-1:0] preset_val;

    always #5 clk = ~clk;

    tff_bank_ctrl_if #(.WIDTH(W)) cmd_if ();

    tff_bank_ctrl #(.WIDTH(W)) u_dut (
        .clk  (clk),
        .rst  (rst),
        .cmd  (cmd_if),
        .q    (q),
        .t    (t),
        .busy (busy),
        .done (done),
        .err  (err)
    );

    // External T flip-flop bank (no reset); preset only used to start from a
    // known non-zero power-up value.
    always @(posedge clk) begin
        if (preset_en) q <= preset_val;
        else           q <= q ^ t;
    end

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef enum int {M_IDLE, M_CLEAR, M_LOAD, M_RUN, M_DONE} mphase_t;
    mphase_t      m_ph, n_ph;
    logic [W-1:0] m_q, n_q, m_ld, n_ld;
    int           m_steps, n_steps;
    bit           m_up, n_up, m_err, n_err;

    task automatic drive(input logic r, input logic v, input logic [1:0] op, input logic [W-1:0] d);
        rst              = r;
        cmd_if.cmd_valid = v;
        cmd_if.cmd_op    = op;
        cmd_if.cmd_data  = d;
    endtask

    // Called at the falling edge: predict this cycle's outputs and the next
    // model state from the current inputs, and compare.
    task automatic check_model();
        logic         rdy, acc;
        logic [W-1:0] nq, diff;
        rdy = !rst && (m_ph == M_IDLE || m_ph == M_RUN);
        acc = cmd_if.cmd_valid && rdy;
        n_ph = m_ph; n_ld = m_ld; n_steps = m_steps; n_up = m_up; n_err = 1'b0;
        nq = m_q;
        if (rst) begin
            n_ph = M_CLEAR;
            n_ld = '0;
        end else begin
            case (m_ph)
                M_CLEAR: begin nq = '0; n_ph = M_IDLE; end
                M_IDLE: if (acc) begin
                    case (cmd_if.cmd_op)
                        2'd0: begin n_ph = M_LOAD; n_ld = cmd_if.cmd_data; end
                        2'd1: begin diff = cmd_if.cmd_data - m_q; n_steps = int'(diff); n_up = 1'b1; n_ph = M_RUN; end
                        2'd2: begin diff = m_q - cmd_if.cmd_data; n_steps = int'(diff); n_up = 1'b0; n_ph = M_RUN; end
                        default: ;
                    endcase
                end
                M_LOAD: begin nq = m_ld; n_ph = M_DONE; end
                M_RUN: begin
                    if (acc && cmd_if.cmd_op == 2'd3) begin
                        n_ph = M_IDLE;
                    end else begin
                        n_err = acc;
                        if (m_steps == 0) n_ph = M_DONE;
                        else begin
                            nq      = m_up ? m_q + 4'd1 : m_q - 4'd1;
                            n_steps = m_steps - 1;
                        end
                    end
                end
                M_DONE: n_ph = M_IDLE;
                default: ;
            endcase
        end
        n_q = nq;
        check("model_t",     t,                nq ^ m_q);
        check("model_ready", cmd_if.cmd_ready, rdy);
        check("model_busy",  busy,             m_ph != M_IDLE);
        check("model_done",  done,             m_ph == M_DONE);
        check("model_err",   err,              m_err);
        check("model_q",     q,                m_q);
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
        m_ph = n_ph; m_q = n_q; m_ld = n_ld; m_steps = n_steps; m_up = n_up; m_err = n_err;
    endtask

    task automatic step_begin(input logic r, input logic v, input logic [1:0] op, input logic [W-1:0] d);
        drive(r, v, op, d);
        @(negedge clk);
        check_model();
    endtask

    task automatic cycle(input logic r, input logic v, input logic [1:0] op, input logic [W-1:0] d);
        step_begin(r, v, op, d);
        advance();
    endtask

    task automatic wait_run_q(input logic [W-1:0] val, input string name);
        bit found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (m_ph == M_RUN && m_q == val) found = 1'b1;
            else cycle(1'b0, 1'b0, 2'd0, '0);
        end
        check(name, found, 1);
    endtask

    task automatic wait_idle(input string name);
        bit found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (m_ph == M_IDLE) found = 1'b1;
            else cycle(1'b0, 1'b0, 2'd0, '0);
        end
        check(name, found, 1);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic         r, v;
        logic [1:0]   op;
        logic [W-1:0] d;
        logic [W-1:0] et;
        logic         erdy, ebusy, edone, eerr;
        logic [W-1:0] eq;
    } vec_t;

    vec_t tbl[30];
    bit   done_seen;

    initial begin
        //         r     v     op    d      t      rdy   busy  done  err   q
        tbl[0]  = '{1'b1, 1'b0, 2'd0, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 4'hB};
        tbl[1]  = '{1'b1, 1'b0, 2'd0, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 4'hB};
        tbl[2]  = '{1'b0, 1'b0, 2'd0, 4'h0, 4'hB, 1'b0, 1'b1, 1'b0, 1'b0, 4'hB};
        tbl[3]  = '{1'b0, 1'b0, 2'd0, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0};
        tbl[4]  = '{1'b0, 1'b1, 2'd0, 4'hA, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0};
        tbl[5]  = '{1'b0, 1'b0, 2'd0, 4'h0, 4'hA, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0};
        tbl[6]  = '{1'b0, 1'b0, 2'd0, 4'h0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0, 4'hA};
        tbl[7]  = '{1'b0, 1'b1, 2'd0, 4'hE, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 4'hA};
        tbl[8]  = '{1'b0, 1'b0, 2'd0, 4'h0, 4'h4, 1'b0, 1'b1, 1'b0, 1'b0, 4'hA};
        tbl[9]  = '{1'b0, 1'b0, 2'd0, 4'h0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0, 4'hE};
        tbl[10] = '{1'b0, 1'b1, 2'd1, 4'h2, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 4'hE};
        tbl[11] = '{1'b0, 1'b0, 2'd0, 4'h0, 4'h1, 1'b1, 1'b1, 1'b0, 1'b0, 4'hE};
        tbl[12] = '{1'b0, 1'b0, 2'd0, 4'h0, 4'hF, 1'b1, 1'b1, 1'b0, 1'b0, 4'hF};
        tbl[13] = '{1'b0, 1'b0, 2'd0, 4'h0, 4'h1, 1'b1, 1'b1, 1'b0, 1'b0, 4'h0};
        tbl[14] = '{1'b0, 1'b0, 2'd0, 4'h0, 4'h3, 1'b1, 1'b1, 1'b0, 1'b0, 4'h1};
        tbl[15] = '{1'b0, 1'b0, 2'd0, 4'h0, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0, 4'h2};
        tbl[16] = '{1'b0, 1'b0, 2'd0, 4'h0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0, 4'h2};
        tbl[17] = '{1'b0, 1'b1, 2'd0, 4'h1, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h2};
        tbl[18] = '{1'b0, 1'b0, 2'd0, 4'h0, 4'h3, 1'b0, 1'b1, 1'b0, 1'b0, 4'h2};
        tbl[19] = '{1'b0, 1'b0, 2'd0, 4'h0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0, 4'h1};
        tbl[20] = '{1'b0, 1'b1, 2'd2, 4'hE, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h1};
        tbl[21] = '{1'b0, 1'b0, 2'd0, 4'h0, 4'h1, 1'b1, 1'b1, 1'b0, 1'b0, 4'h1};
        tbl[22] = '{1'b0, 1'b0, 2'd0, 4'h0, 4'hF, 1'b1, 1'b1, 1'b0, 1'b0, 4'h0};
        tbl[23] = '{1'b0, 1'b0, 2'd0, 4'h0, 4'h1, 1'b1, 1'b1, 1'b0, 1'b0, 4'hF};
        tbl[24] = '{1'b0, 1'b0, 2'd0, 4'h0, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0, 4'hE};
        tbl[25] = '{1'b0, 1'b0, 2'd0, 4'h0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0, 4'hE};
        tbl[26] = '{1'b0, 1'b1, 2'd1, 4'hE, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 4'hE};
        tbl[27] = '{1'b0, 1'b0, 2'd0, 4'h0, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0, 4'hE};
        tbl[28] = '{1'b0, 1'b0, 2'd0, 4'h0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0, 4'hE};
        tbl[29] = '{1'b0, 1'b0, 2'd0, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 4'hE};

        // Power-up: bank holds 4'b1011, first reset edge.
        drive(1'b1, 1'b0, 2'd0, '0);
        preset_en  = 1'b1;
        preset_val = 4'b1011;
        @(posedge clk);
        #1;
        preset_en = 1'b0;
        m_ph = M_CLEAR; m_q = 4'hB; m_ld = '0; m_steps = 0; m_up = 1'b0; m_err = 1'b0;

        // Reset clear, load, count-up wrap, count-down wrap, zero-step count.
        for (int i = 0; i < 30; i++) begin
            drive(tbl[i].r, tbl[i].v, tbl[i].op, tbl[i].d);
            @(negedge clk);
            check($sformatf("vec%0d_t", i),     t,                tbl[i].et);
            check($sformatf("vec%0d_ready", i), cmd_if.cmd_ready, tbl[i].erdy);
            check($sformatf("vec%0d_busy", i),  busy,             tbl[i].ebusy);
            check($sformatf("vec%0d_done", i),  done,             tbl[i].edone);
            check($sformatf("vec%0d_err", i),   err,              tbl[i].eerr);
            check($sformatf("vec%0d_q", i),     q,                tbl[i].eq);
            check_model();
            advance();
        end

        // Drop and stop: LOAD 0, COUNT_UP 9, LOAD at q=3 dropped, STOP at q=5.
        done_seen = 1'b0;
        cycle(1'b0, 1'b1, 2'd0, 4'h0);
        wait_idle("wait_idle_a");
        cycle(1'b0, 1'b1, 2'd1, 4'h9);
        wait_run_q(4'h3, "wait_q3");
        step_begin(1'b0, 1'b1, 2'd0, 4'h5);
        check("drop_ready", cmd_if.cmd_ready, 1'b1);
        advance();
        step_begin(1'b0, 1'b0, 2'd0, 4'h0);
        check("drop_err", err, 1'b1);
        check("drop_continues_q", q, 4'h4);
        advance();
        for (int i = 0; i < 40 && !(m_ph == M_RUN && m_q == 4'h5); i++) begin
            step_begin(1'b0, 1'b0, 2'd0, 4'h0);
            if (done) done_seen = 1'b1;
            advance();
        end
        check("wait_q5", q, 4'h5);
        step_begin(1'b0, 1'b1, 2'd3, 4'h0);
        check("stop_t", t, 4'h0);
        advance();
        for (int i = 0; i < 3; i++) begin
            step_begin(1'b0, 1'b0, 2'd0, 4'h0);
            if (done) done_seen = 1'b1;
            check("stop_idle", busy, 1'b0);
            check("stop_q", q, 4'h5);
            advance();
        end
        check("stop_no_done", done_seen, 1'b0);

        // STOP coinciding with q == tgt.
        cycle(1'b0, 1'b1, 2'd1, 4'h7);
        wait_run_q(4'h7, "wait_q7");
        step_begin(1'b0, 1'b1, 2'd3, 4'h0);
        check("coinc_t", t, 4'h0);
        advance();
        step_begin(1'b0, 1'b0, 2'd0, 4'h0);
        check("coinc_idle", busy, 1'b0);
        check("coinc_no_done", done, 1'b0);
        advance();
        step_begin(1'b0, 1'b0, 2'd0, 4'h0);
        check("coinc_no_done2", done, 1'b0);
        advance();

        // Reset mid-count at q=6.
        cycle(1'b0, 1'b1, 2'd0, 4'h4);
        wait_idle("wait_idle_b");
        cycle(1'b0, 1'b1, 2'd1, 4'h9);
        wait_run_q(4'h6, "wait_q6");
        step_begin(1'b1, 1'b0, 2'd0, 4'h0);
        check("rstmid_t", t, 4'h0);
        advance();
        step_begin(1'b1, 1'b0, 2'd0, 4'h0);
        check("rstmid_hold", q, 4'h6);
        advance();
        step_begin(1'b0, 1'b0, 2'd0, 4'h0);
        check("rstmid_clear_t", t, 4'h6);
        check("rstmid_clear_done", done, 1'b0);
        advance();
        step_begin(1'b0, 1'b0, 2'd0, 4'h0);
        check("rstmid_q0", q, 4'h0);
        check("rstmid_ready", cmd_if.cmd_ready, 1'b1);
        check("rstmid_no_err", err, 1'b0);
        advance();

        // Randomized traffic against the model.
        for (int i = 0; i < 2000; i++) begin
            cycle($urandom_range(0, 99) == 0, 1'($urandom_range(0, 1)),
                  2'($urandom_range(0, 3)), 4'($urandom));
        end
        for (int i = 0; i < 20; i++) cycle(1'b0, 1'b0, 2'd0, 4'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
